// File: rtl/cla_pkg.sv
// Shared constants and FSM state type for the time-shared CLA adder controller.
package cla_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder slice; all carries derived directly from g/p terms.
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_in);
    sum   = p ^ c[3:0];
    c_out = c[4];
  end

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Multi-cycle adder: one cla_4bit slice reused LSB-first, carry chained through a register.
//   state   | meaning
//   IDLE    | ready for operands
//   RUN     | one nibble per cycle through u_slice
//   DONE    | result presented until consumer takes it
module cla_seq_adder_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CW     = $clog2(NSLICE);
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   sum_reg;
  logic               carry;
  logic [CW-1:0]      cnt;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  assign slice_a = op_a[SLICE_W*int'(cnt) +: SLICE_W];
  assign slice_b = op_b[SLICE_W*int'(cnt) +: SLICE_W];

  cla_4bit u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_a  <= in_a;
            op_b  <= in_b;
            carry <= in_cin;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          sum_reg[SLICE_W*int'(cnt) +: SLICE_W] <= slice_sum;
          carry <= slice_cout;
          // explicit wrap keeps non-power-of-two slice counts correct
          cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = sum_reg;
  assign out_cout = carry;
  assign out_ovf  = (op_a[WIDTH-1] == op_b[WIDTH-1]) & (sum_reg[WIDTH-1] != op_a[WIDTH-1]);

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Directed and soak checks for cla_seq_adder_ctrl with a bench-side arithmetic model.
module tb_cla_seq_adder_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cla_seq_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept operands and wait for out_valid; returns edges from accept to out_valid.
  task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                                input int idle_gap, output int lat);
    int guard;
    repeat (idle_gap) step();
    guard = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_a = $urandom(); in_b = $urandom(); in_cin = 1'b1;
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
  endtask

  task automatic full_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input int idle_gap, input int stall);
    int lat;
    logic [W:0]   full;
    logic [W-1:0] es;
    logic         ec, eo;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    es = full[W-1:0];
    ec = full[W];
    eo = (a[W-1] == b[W-1]) && (es[W-1] != a[W-1]);
    start_and_wait(a, b, c, idle_gap, lat);
    chk({tag, "_lat"}, 64'(lat), 64'd8);
    repeat (stall) step();
    chk({tag, "_sum"},  {32'd0, out_sum},  {32'd0, es});
    chk({tag, "_cout"}, {63'd0, out_cout}, {63'd0, ec});
    chk({tag, "_ovf"},  {63'd0, out_ovf},  {63'd0, eo});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0;
    #12;
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_sum",   {32'd0, out_sum},   64'd0);
    chk("rst_out_cout",  {63'd0, out_cout},  64'd0);
    chk("rst_out_ovf",   {63'd0, out_ovf},   64'd0);
    chk("rst_busy",      {63'd0, busy},      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // out_ready while idle is ignored
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("idle_out_ready_ignored", {62'd0, busy, out_valid}, 64'd0);

    full_op("t1_one_plus_one", 32'h0000_0001, 32'h0000_0001, 1'b0, 0, 0);
    full_op("t2_ripple",       32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 0);
    full_op("t3_pos_ovf",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1, 0);

    // t4: stall with a competing in_valid that must not be taken
    start_and_wait(32'h8000_0000, 32'h8000_0000, 1'b0, 0, lat);
    chk("t4_lat", 64'(lat), 64'd8);
    in_a = 32'h1111_1111; in_b = 32'h2222_2222; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_sum",   {32'd0, out_sum},   64'd0);
      chk("t4_stall_cout",  {63'd0, out_cout},  64'd1);
      chk("t4_stall_ovf",   {63'd0, out_ovf},   64'd1);
      chk("t4_stall_valid", {63'd0, out_valid}, 64'd1);
      chk("t4_stall_ready", {63'd0, in_ready},  64'd0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_post_in_ready", {63'd0, in_ready},  64'd1);
    chk("t4_post_valid",    {63'd0, out_valid}, 64'd0);
    chk("t4_post_busy",     {63'd0, busy},      64'd0);

    // t5: reset during the third RUN cycle
    in_a = 32'h1234_5678; in_b = 32'h1111_1111; in_cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("t5_busy_before_rst", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_rst_busy",  {63'd0, busy},      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t5_rel_in_ready", {63'd0, in_ready},  64'd1);
    chk("t5_rel_valid",    {63'd0, out_valid}, 64'd0);
    repeat (10) step();
    chk("t5_no_partial", {63'd0, out_valid}, 64'd0);
    full_op("t5_fresh", 32'h1234_5678, 32'h1111_1111, 1'b0, 0, 0);

    // t6: soak against the bench model
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 3))
        0: ra = 32'hFFFF_FFFF;
        1: rb = ~ra;
        default: ;
      endcase
      full_op("t6_soak", ra, rb, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule
